// File: rtl/async_fifo_lvl.sv
// -----------------------------------------------------------------------------
// async_fifo_lvl
//   Dual-clock FIFO between the ADC/decimation domain (wclk) and the USB/host
//   transfer domain (rclk). Gray-coded pointers cross the clock boundary
//   through 2-flop synchronisers. Both sides keep registered fill levels,
//   threshold flags and sticky error flags.
//
//   Optional feature macro: ASYNC_FIFO_FWFT_EN
//     defined   : first-word-fall-through. An output stage prefetches the head
//                 word. empty=0 exactly when rdata holds valid head data.
//     undefined : standard mode. rdata updates on the rclk edge that accepts
//                 a read (1-cycle registered RAM read) and holds otherwise.
//
// Ports
//   wclk          in   write clock
//   rst_n         in   asynchronous active-low reset, shared by both domains
//   wen           in   write request
//   wdata         in   write data [WIDTH]
//   full          out  FIFO full, exact on assert (wclk)
//   almost_full   out  wlevel >= AF_THRESH, registered (wclk)
//   wlevel        out  fill count seen from the write side [$clog2(DEPTH)+1]
//   overflow      out  sticky: write attempted while full
//   rclk          in   read clock
//   ren           in   read request (acknowledges the head word in FWFT mode)
//   rdata         out  read data [WIDTH]
//   empty         out  FIFO empty, exact on assert (rclk)
//   almost_empty  out  rlevel <= AE_THRESH, registered (rclk)
//   rlevel        out  fill count seen from the read side [$clog2(DEPTH)+1]
//   underflow     out  sticky: read attempted while empty
//
// Handshake: a write is accepted on a wclk edge where wen=1 and full=0; a read
// is accepted on an rclk edge where ren=1 and empty=0. Requests made while the
// flag is set are dropped (pointer unchanged) and raise the sticky error flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module async_fifo_lvl #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 1024,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     wclk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   wlevel,
  output logic                     overflow,
  input  logic                     rclk,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   rlevel,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Reset synchronisers: assert asynchronously, release after 2 local edges.
  logic [1:0] wrst_q;
  logic [1:0] rrst_q;
  logic       wrst_n;
  logic       rrst_n;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) wrst_q <= 2'b00;
    else        wrst_q <= {wrst_q[0], 1'b1};
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) rrst_q <= 2'b00;
    else        rrst_q <= {rrst_q[0], 1'b1};
  end

  assign wrst_n = wrst_q[1];
  assign rrst_n = rrst_q[1];

  // Storage: written in wclk, read in rclk. Never reset; contents are
  // discarded logically by clearing the pointers.
  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [AW:0] wbin, wgray, wbin_next, wlevel_next;
  logic [AW:0] rgray, rgray_w1, rgray_w2, rbin_w;
  logic        w_acc;

  assign w_acc       = wen & ~full;
  assign wbin_next   = wbin + {{AW{1'b0}}, w_acc};
  assign rbin_w      = gray2bin(rgray_w2);
  // rbin_w lags the true read pointer, so this over-reports but never wraps.
  assign wlevel_next = wbin_next - rbin_w;

  always_ff @(posedge wclk) begin
    if (w_acc) mem[wbin[AW-1:0]] <= wdata;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin        <= '0;
      wgray       <= '0;
      rgray_w1    <= '0;
      rgray_w2    <= '0;
      full        <= 1'b1;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= bin2gray(wbin_next);
      rgray_w1    <= rgray;
      rgray_w2    <= rgray_w1;
      full        <= (wlevel_next == DEPTH_L);
      almost_full <= (wlevel_next >= AF_L);
      wlevel      <= wlevel_next;
      if (wen && full) overflow <= 1'b1;
    end
  end

  // ---------------- read domain ----------------
  // rbin counts words handed to the consumer; its Gray copy is what the
  // write side sees, so a slot is only reusable once its word was consumed.
  logic [AW:0] rbin, rbin_next, rlevel_next;
  logic [AW:0] wgray_r1, wgray_r2, wbin_r;

  assign wbin_r = gray2bin(wgray_r2);

`ifdef ASYNC_FIFO_FWFT_EN
  // fbin is the RAM fetch pointer; it runs one ahead of rbin whenever the
  // output stage holds a word (empty=0).
  logic [AW:0] fbin, fbin_next;
  logic        consume, fetch, valid_next;

  assign consume     = ren & ~empty;
  // Refill the stage when it is empty or being drained this edge, giving
  // back-to-back reads at full rate.
  assign fetch       = (fbin != wbin_r) & (empty | consume);
  assign valid_next  = fetch | (~empty & ~ren);
  assign rbin_next   = rbin + {{AW{1'b0}}, consume};
  assign fbin_next   = fbin + {{AW{1'b0}}, fetch};
  // Includes the word parked in the output stage.
  assign rlevel_next = wbin_r - rbin_next;
`else
  logic r_acc;

  assign r_acc       = ren & ~empty;
  assign rbin_next   = rbin + {{AW{1'b0}}, r_acc};
  assign rlevel_next = wbin_r - rbin_next;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin         <= '0;
      rgray        <= '0;
      wgray_r1     <= '0;
      wgray_r2     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rlevel       <= '0;
      underflow    <= 1'b0;
      rdata        <= '0;
`ifdef ASYNC_FIFO_FWFT_EN
      fbin         <= '0;
`endif
    end else begin
      rbin         <= rbin_next;
      rgray        <= bin2gray(rbin_next);
      wgray_r1     <= wgray;
      wgray_r2     <= wgray_r1;
      rlevel       <= rlevel_next;
      almost_empty <= (rlevel_next <= AE_L);
      if (ren && empty) underflow <= 1'b1;
`ifdef ASYNC_FIFO_FWFT_EN
      fbin         <= fbin_next;
      empty        <= ~valid_next;
      if (fetch) rdata <= mem[fbin[AW-1:0]];
`else
      empty        <= (rlevel_next == '0);
      if (r_acc) rdata <= mem[rbin[AW-1:0]];
`endif
    end
  end

endmodule

// File: tb/tb_async_fifo_lvl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_lvl
//   Self-checking bench for async_fifo_lvl (DEPTH=16, WIDTH=32, AF=12, AE=4).
//   wclk ~80 MHz, rclk ~60 MHz. Written data is pushed to exp_q and popped
//   when the FIFO presents it. Handles both the standard and the
//   ASYNC_FIFO_FWFT_EN read modes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_async_fifo_lvl;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LW = 5;
  localparam int N  = 10000;

  logic          wclk = 1'b0;
  logic          rclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          full, almost_full, overflow;
  logic          empty, almost_empty, underflow;
  logic [LW-1:0] wlevel, rlevel;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            lvl_viol = 0;

  // ---------------- clock / reset ----------------
  always #6.25 wclk = ~wclk;
  always #8.333 rclk = ~rclk;

  async_fifo_lvl #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(12), .AE_THRESH(4)
  ) dut (
    .wclk(wclk), .rst_n(rst_n), .wen(wen), .wdata(wdata),
    .full(full), .almost_full(almost_full), .wlevel(wlevel),
    .overflow(overflow),
    .rclk(rclk), .ren(ren), .rdata(rdata), .empty(empty),
    .almost_empty(almost_empty), .rlevel(rlevel), .underflow(underflow)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_qsize"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, got, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_full"}, full, 1);
    check_val({tag, "_afull"}, almost_full, 0);
    check_val({tag, "_wlevel"}, wlevel, 0);
    check_val({tag, "_ovf"}, overflow, 0);
    check_val({tag, "_empty"}, empty, 1);
    check_val({tag, "_aempty"}, almost_empty, 1);
    check_val({tag, "_rlevel"}, rlevel, 0);
    check_val({tag, "_udf"}, underflow, 0);
    check_val({tag, "_rdata"}, rdata, 0);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input bit timed);
    int n;
    rst_n = 1'b0;
    wen = 1'b0;
    ren = 1'b0;
    exp_q.delete();
    #20;
    check_reset_vals("rst");
    rst_n = 1'b1;
    if (timed) begin
      // 2 edges through the synchroniser, then full clears on the next one.
      n = 0;
      do begin
        @(posedge wclk); #1; n++;
      end while (full && n < 10);
      check_val("full_release_edges", n, 3);
    end
    repeat (6) @(negedge wclk);
    repeat (6) @(negedge rclk);
    check_val("post_rst_full", full, 0);
    check_val("post_rst_empty", empty, 1);
  endtask

  task automatic write_word(input logic [W-1:0] d);
    @(negedge wclk);
    wen = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    @(posedge wclk); #1;
    wen = 1'b0;
  endtask

  // Reads one word; returns just after the rclk edge that consumed it.
  task automatic read_one(input string tag);
    int n;
    n = 0;
    @(negedge rclk);
    while (empty && n < 200) begin
      @(negedge rclk); n++;
    end
    if (empty) begin
      check_val({tag, "_timeout"}, empty, 0);
      return;
    end
`ifdef ASYNC_FIFO_FWFT_EN
    pop_check(tag, rdata);
    ren = 1'b1;
    @(posedge rclk); #1;
    ren = 1'b0;
`else
    ren = 1'b1;
    @(posedge rclk); #1;
    ren = 1'b0;
    pop_check(tag, rdata);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, got, wguard, rguard, n;

    #2;
    do_reset(1'b1);

    // Read on an empty FIFO: ignored, sticky underflow.
    @(negedge rclk);
    ren = 1'b1;
    @(posedge rclk); #1;
    ren = 1'b0;
    check_val("t4_udf", underflow, 1);
    check_val("t4_rdata", rdata, 0);
    check_val("t4_rlevel", rlevel, 0);
    check_val("t4_empty", empty, 1);
    repeat (3) @(negedge rclk);
    check_val("t4_udf_sticky", underflow, 1);
    do_reset(1'b0);

    // Fill to full with no reads: levels exact on the write side.
    for (int i = 0; i < D; i++) begin
      write_word(W'(i));
      check_val("t1_wlevel", wlevel, i + 1);
      check_val("t1_full", full, (i == D - 1));
      check_val("t1_afull", almost_full, (i + 1 >= 12));
    end
    check_val("t1_ovf", overflow, 0);

    // Writes while full are dropped and flag overflow.
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      wen = 1'b1;
      wdata = 32'hdead_beef;
      @(posedge wclk); #1;
      check_val("t2_ovf", overflow, 1);
      check_val("t2_full", full, 1);
      check_val("t2_wlevel", wlevel, D);
    end
    wen = 1'b0;
    repeat (10) @(negedge rclk);
    check_val("t2_ovf_sticky", overflow, 1);
    check_val("t2_rlevel_full", rlevel, D);
    for (int j = 0; j < D; j++) begin
      read_one("t2_rd");
      check_val("t2_rlevel", rlevel, D - 1 - j);
      check_val("t2_aempty", almost_empty, (D - 1 - j <= 4));
    end
    check_val("t2_empty", empty, 1);
    check_val("t2_rlevel_end", rlevel, 0);
    check_val("t2_qsize", exp_q.size(), 0);

    // Streaming with random wen/ren.
    do_reset(1'b0);
    k = 0;
    got = 0;
    wguard = 0;
    rguard = 0;
    fork
      begin
        while (k < N && wguard < 40000) begin
          @(negedge wclk);
          wguard++;
          wen = 1'b0;
          if (!full && $urandom_range(0, 3) != 0) begin
            wen = 1'b1;
            wdata = 32'h1000_0000 + W'(k);
            exp_q.push_back(wdata);
            k++;
          end
          if (wlevel > D) lvl_viol++;
        end
        @(negedge wclk);
        wen = 1'b0;
      end
      begin
        while (got < N && rguard < 40000) begin
          @(negedge rclk);
          rguard++;
          ren = 1'b0;
          if (!empty && $urandom_range(0, 3) != 0) begin
`ifdef ASYNC_FIFO_FWFT_EN
            pop_check("t3_rd", rdata);
            ren = 1'b1;
            got++;
`else
            ren = 1'b1;
            @(posedge rclk); #1;
            pop_check("t3_rd", rdata);
            got++;
`endif
          end
          if (rlevel > D) lvl_viol++;
        end
        @(negedge rclk);
        ren = 1'b0;
      end
    join
    check_val("t3_wr_count", k, N);
    check_val("t3_rd_count", got, N);
    check_val("t3_ovf", overflow, 0);
    check_val("t3_udf", underflow, 0);
    check_val("t3_lvl_bound", lvl_viol, 0);
    check_val("t3_qsize", exp_q.size(), 0);
    repeat (6) @(negedge rclk);
    check_val("t3_empty", empty, 1);

    // Asynchronous reset mid-stream with 9 words stored.
    for (int i = 0; i < 9; i++) write_word(32'h5000 + W'(i));
    repeat (10) @(negedge rclk);
    check_val("t5_rlevel_pre", rlevel, 9);
    #3.3;
    rst_n = 1'b0;
    #0.5;
    check_reset_vals("t5_async");
    #0.5;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (6) @(negedge wclk);
    check_val("t5_full", full, 0);
    check_val("t5_wlevel", wlevel, 0);
    repeat (6) @(negedge rclk);
    check_val("t5_empty", empty, 1);
    check_val("t5_rlevel", rlevel, 0);
    for (int i = 0; i < 3; i++) write_word(32'h6000 + W'(i));
    for (int i = 0; i < 3; i++) read_one("t5_rd");
    check_val("t5_empty_end", empty, 1);

`ifdef ASYNC_FIFO_FWFT_EN
    // Single word falls through without any ren.
    do_reset(1'b0);
    write_word(32'h0000_00a5);
    n = 0;
    while (empty && n < 8) begin
      @(posedge rclk); #1; n++;
    end
    check_val("t6_fall_in_5", (n <= 5) && !empty, 1);
    @(negedge rclk);
    pop_check("t6_rdata", rdata);
    ren = 1'b1;
    @(posedge rclk); #1;
    ren = 1'b0;
    check_val("t6_empty_after", empty, 1);
    check_val("t6_rlevel", rlevel, 0);
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
Dual-clock FIFO with Gray-coded pointers, 2-flop pointer synchronisers and a simple dual-port RAM. It generalises the existing async FIFO with several additions:
- registered fill-level counts in both clock domains
- parameterised, registered almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- optional first-word-fall-through read mode

It sits between the ADC/decimation (wclk) and the USB/host transfer (rclk) domains.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 1024, entries; power of two, >= 4
AF_THRESH, DEPTH-4, almost_full asserted when wlevel >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when rlevel <= AE_THRESH

Ports:
wclk  in  1  write clock
rst_n  in  1  reset, asynchronous, active-low (shared by both domains)
wen  in  1  write request
wdata  in  WIDTH  write data
full  out  1  FIFO full (wclk)
almost_full  out  1  registered threshold flag (wclk)
wlevel  out  $clog2(DEPTH)+1  fill count seen from write side
overflow  out  1  sticky: write attempted while full
rclk  in  1  read clock
ren  in  1  read request (ack of head word in FWFT mode)
rdata  out  WIDTH  read data
empty  out  1  FIFO empty (rclk)
almost_empty  out  1  registered threshold flag (rclk)
rlevel  out  $clog2(DEPTH)+1  fill count seen from read side
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset: rst_n asserts asynchronously in both domains. Deassertion passes through a 2-flop synchroniser per domain (wrst_n, rrst_n).
- Values while in reset:
  - full=1, almost_full=0, wlevel=0, overflow=0
  - empty=1, almost_empty=1, rlevel=0, underflow=0
  - both pointers 0; rdata=0
- Flag release after reset: full drops at the first wclk edge after wrst_n releases; empty stays 1.
- Reset mid-operation: all contents are discarded and the values above are restored within 1 edge of each domain's clock, with no partial writes.
- Pointers: (ADDR_WIDTH+1)-bit binary and Gray counters.
  - Write accept = wen & ~full; read accept = ren & ~empty (non-FWFT).
  - Pointers wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
- Synchronisation: each Gray pointer is synchronised by 2 flops into the opposite domain, then converted to binary.
- Level arithmetic is unsigned, ADDR_WIDTH+1 bits, modulo 2^(ADDR_WIDTH+1); the result is always in 0..DEPTH.
  - wlevel_next = wbin_next - rbin_wdomain
  - rlevel_next = wbin_rdomain - rbin_next
- All four flags and both levels are registered, updating on the edge that updates their pointer.
  - full = (wlevel_next == DEPTH); empty = (rlevel_next == 0)
  - almost_full = (wlevel_next >= AF_THRESH); almost_empty = (rlevel_next <= AE_THRESH)
- Flag timing:
  - full and empty assert on the same edge as the causing access (exact).
  - They deassert pessimistically, 2-4 edges of the local clock after the far-side access.
  - wlevel over-reports and rlevel under-reports by at most the synchroniser lag; neither ever wraps.
- Read latency (non-FWFT): rdata updates on the rclk edge of an accepted read (1-cycle registered RAM read). It holds otherwise.
- Errors:
  - wen while full: write ignored, pointer unchanged, overflow set.
  - ren while empty: read ignored, underflow set.
  - Both flags are sticky until reset.
- Simultaneous read and write at full/empty boundaries are legal: each side uses only its own accept term. Simultaneous write and read of the same address is not possible because the flags are exact.
- Equal or unrelated wclk/rclk frequencies are supported; no phase relation is assumed.

Optional Feature:
Macro: ASYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - An internal output stage prefetches the head word; empty=0 exactly when rdata holds valid head data.
  - ren=1 with empty=0 consumes the word; the next word, if present, appears on the same edge sequence (back-to-back reads at full rate).
  - rlevel counts the output-stage word.
  - After the first write into an empty FIFO, empty falls no later than 5 rclk edges after the write edge.
- Undefined: standard mode as described above; no output stage.

Test Plan:
1. Reset, then wclk=80 MHz, rclk=60 MHz, DEPTH=16, write 0..15 with ren=0 -> full=1 on the edge accepting word 15; wlevel=16; almost_full from word 11 (AF_THRESH=12); no overflow.
2. From full, hold wen=1 for 3 cycles -> overflow=1 and stays 1; later reads return exactly 0..15 in order, then empty=1 and rlevel=0.
3. Continuous streaming of 10000 counter words with random ren/wen -> read sequence is gap-free and monotonic; empty/full never accept, no overflow/underflow; pointer wrap crossed more than 600 times.
4. ren=1 on an empty FIFO after reset -> underflow=1, rdata stays 0, rlevel stays 0.
5. Assert rst_n low for 1 ns mid-stream with 9 words stored -> all outputs take reset values asynchronously; after release, full=0 and empty=1; the first word read after new writes is the first word written post-reset.
6. ASYNC_FIFO_FWFT_EN defined, single write of 0xA5 -> empty falls within 5 rclk edges with rdata=0xA5 before any ren; ren for 1 cycle -> empty=1 on the next edge.
